systolic_feeder_2x2: RTL and testbench



---
 rtl/systolic_feeder_2x2.sv | 315 +++++++++++++++++++++++++++++++
 tb/tb_systolic_feeder_2x2.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder_2x2.sv
// systolic_feeder_2x2
//
// Drives the operand side of a 2x2 output-stationary systolic multiply
// array and collects its four accumulators.
//
// On start, A and B are latched. The array is then sequenced through these
// states: CLEAR, FLUSH, STREAM and DRAIN. At the last DRAIN edge the results
// are captured into c_out and done pulses for one cycle.
//
// Build option: define SYSTOLIC_FEEDER_CHECK_EN to add result_err. This
// flag is set at capture when any PE did not report exactly two valid
// products during STREAM/DRAIN.
//
// Handshake: start is sampled only while IDLE (busy=0). A start seen in the
// done cycle begins a new operation. A start seen while busy is dropped.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start                      begin an operation (honoured only in IDLE)
//   a_in  [4*DATA_WIDTH]       {A11,A10,A01,A00}
//   b_in  [4*WEIGHT_WIDTH]     {B11,B10,B01,B00}
//   busy                       high in every non-IDLE state
//   done                       one-cycle pulse, c_out valid
//   c_out [4*ACCUM_WIDTH]      {C11,C10,C01,C00}, held until next capture
//   enable, clear_accum        array control
//   data_in_row*/data_valid_row*      row operand buses to the array
//   weight_in_col*/weight_valid_col*  column operand buses to the array
//   result_xx, valid_xx        accumulators / product strobes from the array
//   result_err                 (option only) valid-count check flag
//   dbg_state                  current FSM state, for observation
module systolic_feeder_2x2 #(
  parameter int DATA_WIDTH   = 16,
  parameter int WEIGHT_WIDTH = 8,
  parameter int ACCUM_WIDTH  = 32,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [4*DATA_WIDTH-1:0]   a_in,
  input  logic [4*WEIGHT_WIDTH-1:0] b_in,
  output logic                      busy,
  output logic                      done,
  output logic [4*ACCUM_WIDTH-1:0]  c_out,
  output logic                      enable,
  output logic                      clear_accum,
  output logic [DATA_WIDTH-1:0]     data_in_row0,
  output logic [DATA_WIDTH-1:0]     data_in_row1,
  output logic                      data_valid_row0,
  output logic                      data_valid_row1,
  output logic [WEIGHT_WIDTH-1:0]   weight_in_col0,
  output logic [WEIGHT_WIDTH-1:0]   weight_in_col1,
  output logic                      weight_valid_col0,
  output logic                      weight_valid_col1,
  input  logic [ACCUM_WIDTH-1:0]    result_00,
  input  logic [ACCUM_WIDTH-1:0]    result_01,
  input  logic [ACCUM_WIDTH-1:0]    result_10,
  input  logic [ACCUM_WIDTH-1:0]    result_11,
  input  logic                      valid_00,
  input  logic                      valid_01,
  input  logic                      valid_10,
  input  logic                      valid_11,
`ifdef SYSTOLIC_FEEDER_CHECK_EN
  output logic                      result_err,
`endif
  output logic [2:0]                dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_FLUSH  = 3'd2,
    S_STREAM = 3'd3,
    S_DRAIN  = 3'd4
  } state_e;

  // The counter must reach max(2, DRAIN_CYCLES-1).
  localparam int CNT_W = (DRAIN_CYCLES > 4) ? $clog2(DRAIN_CYCLES) : 2;
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

  localparam int DW = DATA_WIDTH;
  localparam int WW = WEIGHT_WIDTH;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [4*DW-1:0]           a_q, a_d;
  logic [4*WW-1:0]           b_q, b_d;
  logic [4*ACCUM_WIDTH-1:0]  c_q, c_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      enable_q, enable_d;
  logic                      clear_q, clear_d;
  logic [DW-1:0]             row0_q, row0_d, row1_q, row1_d;
  logic                      rv0_q, rv0_d, rv1_q, rv1_d;
  logic [WW-1:0]             col0_q, col0_d, col1_q, col1_d;
  logic                      cv0_q, cv0_d, cv1_q, cv1_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      end
      S_CLEAR: begin
        if (cnt_q == CNT_W'(2)) begin
          state_d = S_FLUSH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_FLUSH: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_STREAM;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STREAM: begin
        if (cnt_q == CNT_W'(2)) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          c_d     = {result_11, result_10, result_01, result_00};
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Array outputs are registered. They are decoded from the state and
    // count that take effect at this edge, so each bus lines up with its
    // state cycle.
    busy_d   = (state_d != S_IDLE);
    enable_d = busy_d;
    clear_d  = (state_d == S_CLEAR);
    row0_d   = '0;
    row1_d   = '0;
    col0_d   = '0;
    col1_d   = '0;
    rv0_d    = 1'b0;
    rv1_d    = 1'b0;
    cv0_d    = 1'b0;
    cv1_d    = 1'b0;

    case (state_d)
      S_CLEAR: begin
        // Zero operands with valids high. This makes every PE, including
        // PE11 through forwarded valids, take the clear path.
        rv0_d = 1'b1;
        rv1_d = 1'b1;
        cv0_d = 1'b1;
        cv1_d = 1'b1;
      end
      S_STREAM: begin
        // Row i is skewed by i cycles and column j by j cycles, so that
        // A[i][k] meets B[k][j] in PE(i,j).
        case (cnt_d)
          CNT_W'(0): begin
            row0_d = a_q[0*DW +: DW];   // A00
            rv0_d  = 1'b1;
            col0_d = b_q[0*WW +: WW];   // B00
            cv0_d  = 1'b1;
          end
          CNT_W'(1): begin
            row0_d = a_q[1*DW +: DW];   // A01
            rv0_d  = 1'b1;
            row1_d = a_q[2*DW +: DW];   // A10
            rv1_d  = 1'b1;
            col0_d = b_q[2*WW +: WW];   // B10
            cv0_d  = 1'b1;
            col1_d = b_q[1*WW +: WW];   // B01
            cv1_d  = 1'b1;
          end
          CNT_W'(2): begin
            row1_d = a_q[3*DW +: DW];   // A11
            rv1_d  = 1'b1;
            col1_d = b_q[3*WW +: WW];   // B11
            cv1_d  = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      enable_q <= 1'b0;
      clear_q  <= 1'b0;
      row0_q   <= '0;
      row1_q   <= '0;
      rv0_q    <= 1'b0;
      rv1_q    <= 1'b0;
      col0_q   <= '0;
      col1_q   <= '0;
      cv0_q    <= 1'b0;
      cv1_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      enable_q <= enable_d;
      clear_q  <= clear_d;
      row0_q   <= row0_d;
      row1_q   <= row1_d;
      rv0_q    <= rv0_d;
      rv1_q    <= rv1_d;
      col0_q   <= col0_d;
      col1_q   <= col1_d;
      cv0_q    <= cv0_d;
      cv1_q    <= cv1_d;
    end
  end

  assign busy              = busy_q;
  assign done              = done_q;
  assign c_out             = c_q;
  assign enable            = enable_q;
  assign clear_accum       = clear_q;
  assign data_in_row0      = row0_q;
  assign data_in_row1      = row1_q;
  assign data_valid_row0   = rv0_q;
  assign data_valid_row1   = rv1_q;
  assign weight_in_col0    = col0_q;
  assign weight_in_col1    = col1_q;
  assign weight_valid_col0 = cv0_q;
  assign weight_valid_col1 = cv1_q;
  assign dbg_state         = state_q;

`ifdef SYSTOLIC_FEEDER_CHECK_EN
  // Per-PE saturating count of valid strobes seen during STREAM and DRAIN.
  logic [3:0][1:0] vcnt_q, vcnt_d;
  logic            err_q, err_d;
  logic [3:0]      valid_vec;

  assign valid_vec = {valid_11, valid_10, valid_01, valid_00};

  always_comb begin
    vcnt_d = vcnt_q;
    err_d  = err_q;
    if (state_q == S_FLUSH && state_d == S_STREAM) begin
      vcnt_d = '0;
    end else if (state_q == S_STREAM || state_q == S_DRAIN) begin
      for (int i = 0; i < 4; i++) begin
        if (valid_vec[i] && vcnt_q[i] != 2'd3) begin
          vcnt_d[i] = vcnt_q[i] + 2'd1;
        end
      end
    end
    // The capture-edge sample counts: PE11's last product is only
    // reported in the final DRAIN cycle.
    if (done_d) begin
      err_d = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (vcnt_d[i] != 2'd2) begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      vcnt_q <= vcnt_d;
      err_q  <= err_d;
    end
  end

  assign result_err = err_q;
`else
  logic unused_valid;
  assign unused_valid = ^{valid_00, valid_01, valid_10, valid_11};
`endif

endmodule

// File: tb/tb_systolic_feeder_2x2.sv
module tb_systolic_feeder_2x2;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [63:0]  a_in;
  logic [31:0]  b_in;
  logic         busy, done, enable, clear_accum;
  logic [127:0] c_out;
  logic [15:0]  data_in_row0, data_in_row1;
  logic         data_valid_row0, data_valid_row1;
  logic [7:0]   weight_in_col0, weight_in_col1;
  logic         weight_valid_col0, weight_valid_col1;
  logic [31:0]  result_00, result_01, result_10, result_11;
  logic         valid_00, valid_01, valid_10, valid_11;
  logic [2:0]   dbg_state;
`ifdef SYSTOLIC_FEEDER_CHECK_EN
  logic         result_err;
`endif

  int vectors;
  int miscompares;
  logic kill_v11;
  logic [127:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  systolic_feeder_2x2 dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .c_out(c_out), .enable(enable),
    .clear_accum(clear_accum),
    .data_in_row0(data_in_row0), .data_in_row1(data_in_row1),
    .data_valid_row0(data_valid_row0), .data_valid_row1(data_valid_row1),
    .weight_in_col0(weight_in_col0), .weight_in_col1(weight_in_col1),
    .weight_valid_col0(weight_valid_col0), .weight_valid_col1(weight_valid_col1),
    .result_00(result_00), .result_01(result_01),
    .result_10(result_10), .result_11(result_11),
    .valid_00(valid_00), .valid_01(valid_01),
    .valid_10(valid_10), .valid_11(valid_11),
`ifdef SYSTOLIC_FEEDER_CHECK_EN
    .result_err(result_err),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- 2x2 output-stationary array model ----------------
  function automatic logic [31:0] mul(input logic [15:0] a, input logic [7:0] w);
    logic signed [31:0] ae;
    logic signed [31:0] we;
    ae = {{16{a[15]}}, a};
    we = {{24{w[7]}}, w};
    return ae * we;
  endfunction

  logic [15:0] a00_q, a10_q;
  logic        av00_q, av10_q;
  logic [7:0]  w00_q, w01_q;
  logic        wv00_q, wv01_q;
  logic [31:0] acc00, acc01, acc10, acc11;
  logic        vq00, vq01, vq10, vq11;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a00_q <= '0; a10_q <= '0; av00_q <= 1'b0; av10_q <= 1'b0;
      w00_q <= '0; w01_q <= '0; wv00_q <= 1'b0; wv01_q <= 1'b0;
      acc00 <= '0; acc01 <= '0; acc10 <= '0; acc11 <= '0;
      vq00 <= 1'b0; vq01 <= 1'b0; vq10 <= 1'b0; vq11 <= 1'b0;
    end else if (enable) begin
      a00_q  <= data_in_row0;   av00_q <= data_valid_row0;
      a10_q  <= data_in_row1;   av10_q <= data_valid_row1;
      w00_q  <= weight_in_col0; wv00_q <= weight_valid_col0;
      w01_q  <= weight_in_col1; wv01_q <= weight_valid_col1;
      if (clear_accum) begin
        acc00 <= '0; acc01 <= '0; acc10 <= '0; acc11 <= '0;
        vq00 <= 1'b0; vq01 <= 1'b0; vq10 <= 1'b0; vq11 <= 1'b0;
      end else begin
        vq00 <= data_valid_row0 & weight_valid_col0;
        vq01 <= av00_q & weight_valid_col1;
        vq10 <= data_valid_row1 & wv00_q;
        vq11 <= av10_q & wv01_q;
        if (data_valid_row0 && weight_valid_col0) acc00 <= acc00 + mul(data_in_row0, weight_in_col0);
        if (av00_q && weight_valid_col1)          acc01 <= acc01 + mul(a00_q, weight_in_col1);
        if (data_valid_row1 && wv00_q)            acc10 <= acc10 + mul(data_in_row1, w00_q);
        if (av10_q && wv01_q)                     acc11 <= acc11 + mul(a10_q, w01_q);
      end
    end
  end

  assign result_00 = acc00;
  assign result_01 = acc01;
  assign result_10 = acc10;
  assign result_11 = acc11;
  assign valid_00  = vq00;
  assign valid_01  = vq01;
  assign valid_10  = vq10;
  assign valid_11  = vq11 & ~kill_v11;

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [55:0] out_vec();
    return {busy, done, enable, clear_accum, data_valid_row0, data_valid_row1,
            weight_valid_col0, weight_valid_col1, data_in_row0, data_in_row1,
            weight_in_col0, weight_in_col1};
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge: presents operands with start, and returns at the
  // negedge just after the sampling edge.
  task automatic launch(input logic [63:0] a, input logic [31:0] b);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Follows one operation from the cycle after the start edge until done.
  // poke_stream injects a stray start with different operands in STREAM.
  // kill_drain masks valid_11 during DRAIN.
  task automatic wait_done(input string tag, input bit poke_stream, input bit kill_drain);
    int cyc;
    int busy_cnt;
    int clr_cnt;
    logic [127:0] exp_c;
    cyc = 0;
    busy_cnt = 0;
    clr_cnt = 0;
    while (!done && cyc < 40) begin
      if (poke_stream && cyc == 6) begin
        a_in  = {16'd100, 16'd200, 16'd300, 16'd400};
        start = 1'b1;
      end
      if (poke_stream && cyc == 7) start = 1'b0;
      kill_v11 = kill_drain && (cyc >= 8);
      if (busy) busy_cnt++;
      if (clear_accum) clr_cnt++;
      @(negedge clk);
      cyc++;
    end
    kill_v11 = 1'b0;
    check_val({tag, "_latency"}, 128'(cyc), 128'd10);
    check_val({tag, "_busy_cycles"}, 128'(busy_cnt), 128'd10);
    check_val({tag, "_clear_cycles"}, 128'(clr_cnt), 128'd3);
    check_val({tag, "_busy_at_done"}, 128'(busy), 128'd0);
    if (exp_q.size() == 0) begin
      check_val({tag, "_exp_queue_empty"}, 128'd1, 128'd0);
    end else begin
      exp_c = exp_q.pop_front();
      check_val({tag, "_c_out"}, c_out, exp_c);
    end
  endtask

  // ---------------- stimulus ----------------
  localparam logic [63:0]  A_T1 = {16'd4, 16'd3, 16'd2, 16'd1};
  localparam logic [31:0]  B_T1 = {8'd8, 8'd7, 8'd6, 8'd5};
  localparam logic [127:0] C_T1 = {32'd50, 32'd43, 32'd22, 32'd19};
  localparam logic [63:0]  A_T2 = {16'hFFFC, 16'd3, 16'd2, 16'hFFFF};
  localparam logic [31:0]  B_T2 = {8'd8, 8'd7, 8'hFA, 8'd5};
  localparam logic [127:0] C_T2 = {32'hFFFFFFCE, 32'hFFFFFFF3, 32'd22, 32'd9};
  localparam logic [63:0]  A_ID = {16'd1, 16'd0, 16'd0, 16'd1};
  localparam logic [127:0] C_ID = {32'd8, 32'd7, 32'd6, 32'd5};

  initial begin
    int extra_done;
    vectors     = 0;
    miscompares = 0;
    kill_v11    = 1'b0;
    start       = 1'b0;
    a_in        = '0;
    b_in        = '0;
    rst_n       = 1'b0;
    repeat (3) @(negedge clk);

    check_val("reset_outputs", 128'(out_vec()), 128'd0);
    check_val("reset_c_out", c_out, 128'd0);
    check_val("reset_state", 128'(dbg_state), 128'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("idle_outputs", 128'(out_vec()), 128'd0);

    // Basic positive operands.
    exp_q.push_back(C_T1);
    launch(A_T1, B_T1);
    wait_done("t1", 1'b0, 1'b0);
`ifdef SYSTOLIC_FEEDER_CHECK_EN
    check_val("t1_result_err", 128'(result_err), 128'd0);
`endif
    @(negedge clk);
    check_val("t1_done_one_cycle", 128'(done), 128'd0);
    check_val("t1_c_out_hold", c_out, C_T1);

    // Signed operands.
    exp_q.push_back(C_T2);
    launch(A_T2, B_T2);
    wait_done("t2", 1'b0, 1'b0);

    // Back-to-back: new start in the done cycle.
    exp_q.push_back(C_ID);
    launch(A_ID, B_T1);
    wait_done("t3", 1'b0, 1'b0);

    // Stray start during STREAM is ignored.
    @(negedge clk);
    exp_q.push_back(C_T1);
    launch(A_T1, B_T1);
    wait_done("t4", 1'b1, 1'b0);
    extra_done = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) extra_done++;
    end
    check_val("t4_no_second_done", 128'(extra_done), 128'd0);
    check_val("t4_idle_after", 128'(busy), 128'd0);

    // Reset during STREAM, then a fresh run.
    launch(A_T2, B_T2);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("t5_async_reset_outputs", 128'(out_vec()), 128'd0);
    check_val("t5_async_reset_c_out", c_out, 128'd0);
    repeat (2) @(negedge clk);
    check_val("t5_held_reset_outputs", 128'(out_vec()), 128'd0);
    rst_n = 1'b1;
    @(negedge clk);
    exp_q.push_back(C_T1);
    launch(A_T1, B_T1);
    wait_done("t5", 1'b0, 1'b0);

`ifdef SYSTOLIC_FEEDER_CHECK_EN
    check_val("t5_result_err", 128'(result_err), 128'd0);
    @(negedge clk);
    exp_q.push_back(C_T2);
    launch(A_T2, B_T2);
    wait_done("t6", 1'b0, 1'b1);
    check_val("t6_result_err", 128'(result_err), 128'd1);
`endif

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
